// File: rtl/gate_sweep_checker_if.sv
// Pin bundle between gate_sweep_checker and the lab harness driving/observing it.
// master = harness side (start, DUT response); slave = checker side.
interface gate_sweep_checker_if;
  logic       in_start;
  logic       in_dut;
  logic       out_a;
  logic       out_b;
  logic       out_c;
  logic       out_busy;
  logic       out_done;
  logic       out_pass;
  logic [3:0] out_err_cnt;
  logic [2:0] out_first_err_idx;

  modport master (
    output in_start, in_dut,
    input  out_a, out_b, out_c, out_busy, out_done, out_pass,
    input  out_err_cnt, out_first_err_idx
  );

  modport slave (
    input  in_start, in_dut,
    output out_a, out_b, out_c, out_busy, out_done, out_pass,
    output out_err_cnt, out_first_err_idx
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Sweeps all eight 3-input vectors into a combinational gate and checks each against TRUTH.
// Optional macro CHK_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module gate_sweep_checker #(
  parameter int unsigned HOLD_CYCLES = 5,
  parameter logic [7:0]  TRUTH       = 8'hFE
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_sweep_checker_if.slave chk
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  function automatic logic expected_bit(input logic [2:0] idx);
    return TRUTH[idx];
  endfunction

  state_t     r_state,     w_state;
  logic [2:0] r_idx,       w_idx;
  logic [7:0] r_hold,      w_hold;
  logic [3:0] r_err_cnt,   w_err_cnt;
  logic [2:0] r_first_err, w_first_err;
  logic       r_pass,      w_pass;
  logic       r_busy,      w_busy;
  logic       r_done,      w_done;
  logic [2:0] r_vec,       w_vec;
  logic       w_mismatch;
  logic       w_stop;

  // Next-state, counters and next registered-output values.
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_hold      = r_hold;
    w_err_cnt   = r_err_cnt;
    w_first_err = r_first_err;
    w_pass      = r_pass;
    w_mismatch  = 1'b0;
    w_stop      = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (chk.in_start) begin
          w_state     = ST_RUN;
          w_idx       = 3'd0;
          w_hold      = 8'd0;
          w_err_cnt   = 4'd0;
          w_first_err = 3'd0;
          w_pass      = 1'b0;
        end else begin
          w_state = r_state;
        end
      end
      ST_RUN: begin
        if (r_hold == HOLD_LAST) begin
          w_mismatch = (chk.in_dut != expected_bit(r_idx));
          if (w_mismatch) begin
            w_err_cnt = r_err_cnt + 4'd1;
            if (r_err_cnt == 4'd0) begin
              w_first_err = r_idx;
            end else begin
              w_first_err = r_first_err;
            end
          end else begin
            w_err_cnt = r_err_cnt;
          end
`ifdef CHK_STOP_ON_ERR_EN
          w_stop = w_mismatch && (r_err_cnt == 4'd0);
`else
          w_stop = 1'b0;
`endif
          // Pass is decided once, on entry to DONE, and then held.
          if ((r_idx == 3'd7) || w_stop) begin
            w_state = ST_DONE;
            w_pass  = (w_err_cnt == 4'd0);
          end else begin
            w_idx  = r_idx + 3'd1;
            w_hold = 8'd0;
          end
        end else begin
          w_hold = r_hold + 8'd1;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    w_busy = (w_state == ST_RUN);
    w_done = (w_state == ST_DONE);
    if (w_busy) begin
      w_vec = w_idx;
    end else begin
      w_vec = 3'd0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 3'd0;
      r_hold      <= 8'd0;
      r_err_cnt   <= 4'd0;
      r_first_err <= 3'd0;
      r_pass      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vec       <= 3'd0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_hold      <= w_hold;
      r_err_cnt   <= w_err_cnt;
      r_first_err <= w_first_err;
      r_pass      <= w_pass;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_vec       <= w_vec;
    end
  end

  assign chk.out_a             = r_vec[2];
  assign chk.out_b             = r_vec[1];
  assign chk.out_c             = r_vec[0];
  assign chk.out_busy          = r_busy;
  assign chk.out_done          = r_done;
  assign chk.out_pass          = r_pass & r_done;
  assign chk.out_err_cnt       = r_err_cnt;
  assign chk.out_first_err_idx = r_first_err;

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking stimulus/response engine for the 3-input gate labs: drives all eight input combinations into a combinational DUT, samples the DUT output at the end of each hold window and compares it against a parameterised truth table. It sits at the DUT's input and output pins in place of hand-written initial-block stimulus. It reports done, pass/fail, an error count and the first failing vector.

## Interface
- HOLD_CYCLES, 5: clock cycles each vector is held; legal range 1..255.
- TRUTH, 8'hFE: expected DUT output; bit k is the expected value for vector index k (default = 3-input OR).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- in_start  input  1  start request; sampled on the rising edge.
- in_dut  input  1  DUT response (e.g. out_sum of the gate under test).
- out_a  output  1  DUT input a = vector index bit 2.
- out_b  output  1  DUT input b = vector index bit 1.
- out_c  output  1  DUT input c = vector index bit 0.
- out_busy  output  1  sweep in progress.
- out_done  output  1  sweep finished; held until next start or reset.
- out_pass  output  1  valid with out_done; 1 = no mismatches.
- out_err_cnt  output  4  mismatch count, 0..8.
- out_first_err_idx  output  3  index of first mismatching vector; 0 when out_err_cnt = 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: out_a/b/c = 0, busy = 0, done = 0. in_start = 1 -> RUN, clear idx, hold counter, err_cnt, first_err_idx, pass.
- RUN: busy = 1; drive {out_a,out_b,out_c} = idx. Hold counter counts 0..HOLD_CYCLES-1. On the edge where hold = HOLD_CYCLES-1:
  - mismatch if in_dut != TRUTH[idx]; on mismatch increment err_cnt; if err_cnt was 0, latch first_err_idx = idx.
  - idx < 7: idx + 1, hold = 0.
  - idx = 7: -> DONE.
- DONE: busy = 0, done = 1, pass = (err_cnt = 0), out_a/b/c = 0, err_cnt and first_err_idx held. in_start = 1 -> RUN with full clear (done drops on that edge).
- in_start during RUN is ignored.
- Sweep order: 000, 001, 010, 011, 100, 101, 110, 111 (a is MSB).
- err_cnt needs no saturation: at most 8 mismatches.

## Timing
- Reset (rst_n = 0 at an edge): state IDLE; all outputs 0, including out_pass; all counters 0. Reset asserted mid-RUN aborts the sweep with no partial result retained.
- Start latency: in_start sampled at edge E0; vector 0 appears on out_a/b/c and busy = 1 after E0.
- Vector k is driven from E0 + k*HOLD_CYCLES to E0 + (k+1)*HOLD_CYCLES. in_dut is sampled at edge E0 + (k+1)*HOLD_CYCLES.
- out_err_cnt and out_first_err_idx update after the sampling edge.
- done = 1 and busy = 0 after edge E0 + 8*HOLD_CYCLES. Default total is 40 cycles.
- HOLD_CYCLES = 1: new vector every cycle; the DUT path must settle within one clock.
- Start and reset on the same edge: reset wins.

## Configuration
- CHK_STOP_ON_ERR_EN defined: on the sampling edge that records the first mismatch, go to DONE instead of advancing. err_cnt = 1, pass = 0, remaining vectors are not driven.
- CHK_STOP_ON_ERR_EN undefined: always sweep all 8 vectors; err_cnt reports total mismatches.

## Test plan
- OR model on in_dut, defaults, start at E0 -> done after E0+40, pass = 1, err_cnt = 0, first_err_idx = 0; out_a/b/c step 000..111 every 5 cycles.
- in_dut tied 0 -> err_cnt = 7, first_err_idx = 1, pass = 0. in_dut tied 1 -> err_cnt = 1, first_err_idx = 0, pass = 0.
- TRUTH = 8'h80 with AND model, HOLD_CYCLES = 1 -> done after E0+8, pass = 1.
- in_start pulsed during RUN -> timing unchanged. in_start in DONE -> done = 0 next cycle, new sweep from vector 0, counters cleared.
- rst_n low for one edge while idx = 3 -> next cycle all outputs 0, state IDLE; a later start gives a full clean sweep.
- CHK_STOP_ON_ERR_EN defined, in_dut tied 0, defaults -> done after E0+10, err_cnt = 1, first_err_idx = 1, out_a/b/c = 000 afterwards.
